// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// It drives the load enables and synchronous bubble clears of the PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch
// flushes, multi-cycle mult/div occupancy of EX, and halt/resume. It also keeps
// wrapping stall and flush statistics counters.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   id_rs, id_rt              source fields of the ID instruction
//   id_uses_rs, id_uses_rt    ID instruction actually reads rs / rt
//   ex_mem_read, ex_rd        EX instruction is a load, and its destination
//   branch_taken              taken branch/jump resolved in EX
//   md_start                  EX instruction is a mult/div
//   halt_req, resume          halt syscall in WB / leave HALT
//   *_en, *_clr               pipeline register enables and bubble clears
//   halted                    controller is in HALT
//   stall_count, flush_count  wrapping statistics
module pipeline_hazard_ctrl #(
    parameter int unsigned DATA_BITS     = 32,
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned MD_CYCLES     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_BITS-1:0] id_rs,
    input  logic [REG_ADDR_BITS-1:0] id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     ex_mem_read,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    input  logic                     branch_taken,
    input  logic                     md_start,
    input  logic                     halt_req,
    input  logic                     resume,
    output logic                     pc_en,
    output logic                     ifid_en,
    output logic                     idex_en,
    output logic                     exmem_en,
    output logic                     memwb_en,
    output logic                     ifid_clr,
    output logic                     idex_clr,
    output logic                     exmem_clr,
    output logic                     halted,
    output logic [DATA_BITS-1:0]     stall_count,
    output logic [DATA_BITS-1:0]     flush_count
);

    // The md_start cycle counts as the first freeze cycle, so MD_BUSY starts one lower.
    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE, HALT} state_t;

    state_t     state, state_nx;
    logic [7:0] md_cnt, md_cnt_nx;
    logic       lu;
    logic       stall_inc, flush_inc;

    // Load-use hazard: r0 is never a real dependency.
    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    // Next-state and pipeline control decode.
    always_comb begin
        state_nx  = state;
        md_cnt_nx = md_cnt;
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        halted    = 1'b0;
        flush_inc = 1'b0;

        case (state)
            RUN, MD_DONE: begin
                state_nx = RUN;
                if (halt_req) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                    state_nx = HALT;
                end else if (branch_taken) begin
                    ifid_clr  = 1'b1;
                    idex_clr  = 1'b1;
                    flush_inc = 1'b1;
                end else if (md_start && (state == RUN)) begin
                    // MD_DONE ignores md_start: the same mult/div is still sitting in EX.
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_en   = 1'b0;
                    exmem_clr = 1'b1;
                    if (MD_CYCLES == 1) begin
                        state_nx = MD_DONE;
                    end else begin
                        state_nx  = MD_BUSY;
                        md_cnt_nx = MD_LOAD;
                    end
                end else if (lu) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_clr = 1'b1;
                end
            end
            MD_BUSY: begin
                if (halt_req) begin
                    // Abandon the mult/div; it re-issues from EX after resume.
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                    state_nx  = HALT;
                    md_cnt_nx = 8'd0;
                end else begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_en   = 1'b0;
                    exmem_clr = 1'b1;
                    if (md_cnt == 8'd1) begin
                        state_nx = MD_DONE;
                    end else begin
                        md_cnt_nx = md_cnt - 8'd1;
                    end
                end
            end
            HALT: begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                halted = 1'b1;
                if (resume && !halt_req) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase

        // Everything quiet while reset is held, independent of the clock.
        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            {ifid_clr, idex_clr, exmem_clr, halted}       = 4'b0;
            flush_inc = 1'b0;
        end

        stall_inc = !pc_en && (state != HALT);
    end

    // State, md counter and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            md_cnt      <= 8'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
            if (stall_inc) begin
                stall_count <= stall_count + DATA_BITS'(1);
            end
            if (flush_inc) begin
                flush_count <= flush_count + DATA_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver applies directed vectors and
// queues hand-computed expectations; a monitor compares on the falling edge.
// Two instances: MD_CYCLES=8 (sel 0) and MD_CYCLES=1 (sel 1), sharing inputs.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned DB = 32;
    localparam int unsigned RB = 5;

    // Output vector order: pc, ifid, idex, exmem, memwb, ifid_clr, idex_clr, exmem_clr, halted
    localparam logic [8:0] O_RUN = 9'b11111_000_0;
    localparam logic [8:0] O_LU  = 9'b00111_010_0;
    localparam logic [8:0] O_BR  = 9'b11111_110_0;
    localparam logic [8:0] O_MD  = 9'b00011_001_0;
    localparam logic [8:0] O_HLT = 9'b00000_000_1;
    localparam logic [8:0] O_OFF = 9'b00000_000_0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RB-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic          branch_taken = 1'b0, md_start = 1'b0, halt_req = 1'b0, resume = 1'b0;

    logic [8:0]    o8, o1;
    logic [DB-1:0] sc8, fc8, sc1, fc1;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DATA_BITS(DB), .REG_ADDR_BITS(RB), .MD_CYCLES(8)) dut8 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .md_start(md_start), .halt_req(halt_req), .resume(resume),
        .pc_en(o8[8]), .ifid_en(o8[7]), .idex_en(o8[6]), .exmem_en(o8[5]), .memwb_en(o8[4]),
        .ifid_clr(o8[3]), .idex_clr(o8[2]), .exmem_clr(o8[1]), .halted(o8[0]),
        .stall_count(sc8), .flush_count(fc8)
    );

    pipeline_hazard_ctrl #(.DATA_BITS(DB), .REG_ADDR_BITS(RB), .MD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .md_start(md_start), .halt_req(halt_req), .resume(resume),
        .pc_en(o1[8]), .ifid_en(o1[7]), .idex_en(o1[6]), .exmem_en(o1[5]), .memwb_en(o1[4]),
        .ifid_clr(o1[3]), .idex_clr(o1[2]), .exmem_clr(o1[1]), .halted(o1[0]),
        .stall_count(sc1), .flush_count(fc1)
    );

    typedef struct {
        string       name;
        logic        sel;
        logic [8:0]  o;
        int unsigned s;
        int unsigned f;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic push(input string nm, input logic sel, input logic [8:0] o,
                        input int unsigned s, input int unsigned f);
        exp_t e;
        e.name = nm; e.sel = sel; e.o = o; e.s = s; e.f = f;
        q.push_back(e);
    endtask

    // lm: 0 no hazard inputs, 1 load-use on rs=$5, 2 load to $0, 3 rt matches but rt unused
    task automatic step(input string nm, input logic sel, input logic r, input int lm,
                        input logic br, input logic md, input logic hr, input logic rs_m,
                        input logic [8:0] o, input int unsigned s, input int unsigned f);
        @(posedge clk);
        #1;
        rst          = r;
        ex_mem_read  = (lm != 0);
        ex_rd        = (lm == 1) ? RB'(5) : (lm == 3) ? RB'(7) : RB'(0);
        id_rs        = RB'(5);
        id_rt        = RB'(7);
        id_uses_rs   = (lm == 1) || (lm == 2);
        id_uses_rt   = 1'b0;
        branch_taken = br;
        md_start     = md;
        halt_req     = hr;
        resume       = rs_m;
        push(nm, sel, o, s, f);
    endtask

    // Monitor: the DUT presents its controls every cycle; one expectation per cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [8:0]  ao;
            logic [DB-1:0] as, af;
            e  = q.pop_front();
            ao = e.sel ? o1 : o8;
            as = e.sel ? sc1 : sc8;
            af = e.sel ? fc1 : fc8;
            n_chk++;
            if (ao !== e.o || as !== DB'(e.s) || af !== DB'(e.f)) begin
                n_err++;
                $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                         e.name, ao, as, af, e.o, e.s, e.f);
            end
        end
    end

    initial begin
        // Reset state
        step("in_reset",   0, 1, 0, 0, 0, 0, 0, O_OFF, 0, 0);
        step("run_idle",   0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 0);
        // Load-use
        step("lu_stall",   0, 0, 1, 0, 0, 0, 0, O_LU,  0, 0);
        step("lu_after",   0, 0, 0, 0, 0, 0, 0, O_RUN, 1, 0);
        step("lu_rd0",     0, 0, 2, 0, 0, 0, 0, O_RUN, 1, 0);
        step("lu_rt_off",  0, 0, 3, 0, 0, 0, 0, O_RUN, 1, 0);
        // Branch beats load-use
        step("br_lu",      0, 0, 1, 1, 0, 0, 0, O_BR,  1, 0);
        step("br_after",   0, 0, 0, 0, 0, 0, 0, O_RUN, 1, 1);
        // Full 8-cycle mult/div, md_start held through MD_DONE
        step("md_start",   0, 0, 0, 0, 1, 0, 0, O_MD,  1, 1);
        for (int i = 0; i < 7; i++)
            step("md_busy", 0, 0, 0, 0, 1, 0, 0, O_MD, 2 + i, 1);
        step("md_done",    0, 0, 0, 0, 1, 0, 0, O_RUN, 9, 1);
        step("md_run",     0, 0, 0, 0, 0, 0, 0, O_RUN, 9, 1);
        // Halt during MD_BUSY at counter 4
        step("md2_start",  0, 0, 0, 0, 1, 0, 0, O_MD,  9, 1);
        step("md2_c7",     0, 0, 0, 0, 1, 0, 0, O_MD, 10, 1);
        step("md2_c6",     0, 0, 0, 0, 1, 0, 0, O_MD, 11, 1);
        step("md2_c5",     0, 0, 0, 0, 1, 0, 0, O_MD, 12, 1);
        step("md2_c4_hlt", 0, 0, 0, 0, 1, 1, 0, O_OFF, 13, 1);
        step("halt_hold",  0, 0, 0, 0, 1, 0, 0, O_HLT, 14, 1);
        step("halt_both",  0, 0, 0, 0, 1, 1, 1, O_HLT, 14, 1);
        step("halt_resum", 0, 0, 0, 0, 1, 0, 1, O_HLT, 14, 1);
        step("md3_start",  0, 0, 0, 0, 1, 0, 0, O_MD, 14, 1);
        for (int i = 0; i < 7; i++)
            step("md3_busy", 0, 0, 0, 0, 1, 0, 0, O_MD, 15 + i, 1);
        step("md3_done",   0, 0, 0, 0, 0, 0, 0, O_RUN, 22, 1);
        step("md3_run",    0, 0, 0, 0, 0, 0, 0, O_RUN, 22, 1);
        // Halt from RUN
        step("hlt_entry",  0, 0, 0, 0, 0, 1, 0, O_OFF, 22, 1);
        step("hlt_idle",   0, 0, 0, 0, 0, 0, 0, O_HLT, 23, 1);
        step("hlt_resume", 0, 0, 0, 0, 0, 0, 1, O_HLT, 23, 1);
        step("hlt_run",    0, 0, 0, 0, 0, 0, 0, O_RUN, 23, 1);
        // Async reset in the middle of MD_BUSY
        step("md4_start",  0, 0, 0, 0, 1, 0, 0, O_MD, 23, 1);
        step("md4_c7",     0, 0, 0, 0, 1, 0, 0, O_MD, 24, 1);
        step("md4_c6",     0, 0, 0, 0, 1, 0, 0, O_MD, 25, 1);
        @(posedge clk);
        #1;
        md_start = 1'b0;
        #2;
        rst = 1'b1;
        push("async_rst", 0, O_OFF, 0, 0);
        step("rst_rel8",   0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 0);
        // MD_CYCLES=1 instance
        step("m1_start",   1, 0, 0, 0, 1, 0, 0, O_MD,  0, 0);
        step("m1_done",    1, 0, 0, 0, 1, 0, 0, O_RUN, 1, 0);
        step("m1_rerun",   1, 0, 0, 0, 1, 0, 0, O_MD,  1, 0);
        step("m1_done2",   1, 0, 0, 0, 0, 0, 0, O_RUN, 2, 0);
        step("m1_idle",    1, 0, 0, 0, 0, 0, 0, O_RUN, 2, 0);
        // Halt outranks branch
        step("hlt_br",     1, 0, 0, 1, 0, 1, 0, O_OFF, 2, 0);
        step("hlt_br_h",   1, 0, 0, 0, 0, 0, 0, O_HLT, 3, 0);
        step("hlt_br_res", 1, 0, 0, 0, 0, 0, 1, O_HLT, 3, 0);
        step("hlt_br_run", 1, 0, 0, 0, 0, 0, 0, O_RUN, 3, 0);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and synchronous-clear controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch flushes, multi-cycle mult/div occupancy of EX, and halt/resume.
- Keeps wrapping stall and flush statistics counters.

Parameters:
- DATA_BITS, 32, width of the statistics counters.
- REG_ADDR_BITS, 5, register-file address width.
- MD_CYCLES, 8, total freeze cycles for a mult/div in EX (legal range 1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- id_rs  input  REG_ADDR_BITS  rs field of the instruction in ID.
- id_rt  input  REG_ADDR_BITS  rt field of the instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rd  input  REG_ADDR_BITS  destination register of the EX instruction.
- branch_taken  input  1  taken branch/jump resolved in EX.
- md_start  input  1  instruction in EX is mult/div.
- halt_req  input  1  halt syscall is in WB.
- resume  input  1  leave HALT.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  register load enables.
- ifid_clr, idex_clr, exmem_clr  output  1 each  synchronous bubble-insert controls.
- halted  output  1  controller is in HALT.
- stall_count  output  DATA_BITS  cycles with pc_en=0 outside HALT.
- flush_count  output  DATA_BITS  number of branch flushes.

Behaviour:
- States: RUN, MD_BUSY, MD_DONE, HALT. The md counter is 8 bits.
- Reset:
  - State goes to RUN, md counter to 0, both statistics counters to 0.
  - While rst=1, all enables=0, all clears=0, halted=0.
- Outputs are combinational from state and inputs. Default in RUN/MD_DONE: all en=1, all clr=0.
- Load-use hazard (lu) = ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority, highest first, evaluated in RUN/MD_DONE:
  1. halt_req:
     - All en=0, all clr=0.
     - Next state HALT.
  2. branch_taken:
     - pc_en=1, ifid_clr=1, idex_clr=1.
     - flush_count+1.
     - md_start and lu are ignored.
  3. md_start, evaluated in RUN only; ignored in MD_DONE:
     - pc_en=ifid_en=idex_en=0, exmem_clr=1.
     - If MD_CYCLES=1: next state MD_DONE.
     - Otherwise: next state MD_BUSY, md counter loaded with MD_CYCLES-1.
  4. lu:
     - pc_en=0, ifid_en=0, idex_clr=1.
     - Exactly one stall cycle; the load then advances to MEM and lu drops.
- MD_BUSY:
  - pc_en=ifid_en=idex_en=0, exmem_clr=1; MEM/WB keeps running.
  - If counter=1: next state MD_DONE. Otherwise decrement.
  - halt_req in MD_BUSY: go to HALT and clear the md counter; the mult/div restarts after resume.
- Total freeze length for a mult/div = MD_CYCLES cycles, counting the md_start cycle.
- MD_DONE:
  - One cycle with normal outputs; the mult/div result is captured into EX/MEM.
  - Next state RUN unless halt_req.
- HALT:
  - All en=0, all clr=0, halted=1, counters frozen.
  - resume → RUN.
  - halt_req and resume together → stay in HALT.
- stall_count increments on every cycle with pc_en=0 and state≠HALT, including the halt_req entry cycle.
- Both statistics counters wrap from 2^DATA_BITS-1 to 0.
- Reset mid-MD_BUSY or mid-HALT returns to RUN with counters at 0.

Test Plan:
1. Load to $5 in EX, ID reads rs=$5:
   - One cycle with pc_en=0, ifid_en=0, idex_clr=1, stall_count=1.
   - Same case with ex_rd=0 → no stall.
2. branch_taken together with a simultaneous lu:
   - ifid_clr=idex_clr=1, pc_en=1, flush_count=1, stall_count unchanged.
3. md_start with MD_CYCLES=8:
   - 8 consecutive cycles with pc_en=0 and exmem_clr=1.
   - Then MD_DONE with md_start still high → no re-freeze; stall_count=8.
4. MD_CYCLES=1:
   - Single freeze cycle, then MD_DONE, then RUN.
5. halt_req during MD_BUSY at counter=4:
   - HALT, halted=1, all en=0 until a resume pulse.
   - After resume: RUN; md_start held high → a fresh 8-cycle freeze.
6. Async rst asserted mid-clock during MD_BUSY:
   - Outputs go low immediately.
   - After release: RUN, all en=1, stall_count=0, flush_count=0.
